restoring_div_16x8_spst: RTL and testbench
==========================================

RESTORING_DIV_16X8_SPST -- requirements
Module: restoring_div_16x8_spst

Interface
REQ-001 SHALL have parameters: none; widths fixed at 16-bit dividend, 8-bit divisor.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port s_valid  input  1  operand pair valid.
REQ-005 SHALL have port s_ready  output  1  block can accept operands.
REQ-006 SHALL have port s_dividend  input  16  unsigned dividend.
REQ-007 SHALL have port s_divisor  input  8  unsigned divisor.
REQ-008 SHALL have port m_valid  output  1  result valid.
REQ-009 SHALL have port m_ready  input  1  downstream accepts result.
REQ-010 SHALL have port m_quotient  output  16  unsigned quotient.
REQ-011 SHALL have port m_remainder  output  8  unsigned remainder.
REQ-012 SHALL have port m_div_by_zero  output  1  divisor-was-zero flag, qualified by m_valid.

Function
REQ-013 SHALL implement FSM with states IDLE, CALC, DONE.
REQ-014 SHALL drive s_ready = 1 only in IDLE with rst low; 0 in CALC, DONE, and while rst is high.
REQ-015 SHALL accept operands on a rising edge where s_valid && s_ready; operands are registered internally, so inputs may change after acceptance.
REQ-016 SHALL, on acceptance with divisor != 0 and dividend != 0: load a 9-bit partial remainder = 0, a 16-bit quotient/shift register = dividend, and a 5-bit counter = 0; then go to CALC.
REQ-017 SHALL, in CALC, each cycle: shift {remainder, quotient} left by 1; if shifted remainder >= divisor, subtract the divisor and set quotient LSB = 1, else set it to 0; increment the counter.
REQ-018 SHALL, on the 16th CALC edge (counter == 15), register the final quotient and remainder into the outputs, set m_valid = 1, and go to DONE; m_valid is therefore high 16 edges after the accept edge.
REQ-019 SHALL (SPST skip), on acceptance with divisor == 0: go directly to DONE at the accept edge with m_quotient = 16'hFFFF, m_remainder = dividend[7:0], m_div_by_zero = 1, m_valid = 1.
REQ-020 SHALL (SPST skip), on acceptance with dividend == 0 and divisor != 0: go directly to DONE at the accept edge with m_quotient = 0, m_remainder = 0, m_div_by_zero = 0, m_valid = 1.
REQ-021 SHALL give divisor == 0 priority over dividend == 0 (0/0 -> div-by-zero result, remainder 0).
REQ-022 SHALL, in DONE, hold m_valid, m_quotient, m_remainder, m_div_by_zero stable while m_ready == 0.
REQ-023 SHALL, on an edge with m_valid && m_ready, clear m_valid and go to IDLE; s_ready rises the following cycle, with no same-cycle accept from DONE.
REQ-024 SHALL ignore s_valid outside IDLE; there is no buffering, so upstream holds its data per handshake.
REQ-025 SHALL ensure the result always satisfies quotient*divisor + remainder == dividend and remainder < divisor for divisor != 0.
REQ-026 SHALL drive m_div_by_zero = 0 for every nonzero-divisor result.
REQ-027 SHALL not preserve outputs from a previous result into a new one; the output registers are overwritten only at result generation.

Reset
REQ-028 SHALL, while rst is high, force state = IDLE, m_valid = 0, m_quotient = 0, m_remainder = 0, m_div_by_zero = 0, internal remainder, shift register and counter = 0.
REQ-029 SHALL, on rst asserted mid-CALC or mid-DONE, abort the operation immediately with no result emitted after deassertion; the first edge after deassertion is in IDLE.

Verification
REQ-030 SHALL pass: 1000 / 7, m_ready = 1 -> m_valid 16 edges after accept, q = 142, r = 6, dbz = 0; s_ready high again one cycle after handshake.
REQ-031 SHALL pass: 16'hFFFF / 1 -> q = 16'hFFFF, r = 0, dbz = 0; and 16'hFFFF / 255 -> q = 257, r = 0.
REQ-032 SHALL pass: 500 / 0 -> m_valid on the accept edge, q = 16'hFFFF, r = 8'hF4, dbz = 1; and 0 / 37 -> m_valid on the accept edge, q = 0, r = 0, dbz = 0.
REQ-033 SHALL pass: 1234 / 10 with m_ready low for 5 cycles after m_valid -> outputs q = 123, r = 4 stable throughout; s_ready stays 0 with s_valid held high; one handshake only.
REQ-034 SHALL pass: rst pulse at CALC cycle 8 of 40000 / 3 -> m_valid never rises; the next op 9 / 4 yields q = 2, r = 1.
REQ-035 SHALL pass: 200 back-to-back random operand pairs with random m_ready -> every result matches the reference model and each is emitted exactly once.

Source files
------------

// File: rtl/restoring_div_16x8_spst.sv
// 16/8 unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Zero divisor or zero dividend skips the iteration and produces a result on the accept edge.
module restoring_div_16x8_spst (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_dividend,
  input  logic [7:0]  s_divisor,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_quotient,
  output logic [7:0]  m_remainder,
  output logic        m_div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [8:0]  r_rem;
  logic [15:0] r_q;
  logic [4:0]  r_cnt;
  logic [7:0]  r_div;
  logic [15:0] r_mq;
  logic [7:0]  r_mr;
  logic        r_dbz;

  logic        w_accept;
  logic        w_skip;
  logic        w_last;
  logic [9:0]  w_shift;
  logic [9:0]  w_diff;
  logic        w_ge;
  logic [8:0]  w_rem_nxt;
  logic [15:0] w_q_nxt;

  assign s_ready       = (r_state == IDLE) && !rst;
  assign m_valid       = (r_state == DONE);
  assign m_quotient    = r_mq;
  assign m_remainder   = r_mr;
  assign m_div_by_zero = r_dbz;

  assign w_accept = s_valid && s_ready;
  assign w_skip   = (s_divisor == 8'd0) || (s_dividend == 16'd0);
  assign w_last   = (r_cnt == 5'd15);

  // Extra borrow bit: a negative trial difference shows up in w_diff[9].
  assign w_shift   = {r_rem, r_q[15]};
  assign w_diff    = w_shift - {2'b00, r_div};
  assign w_ge      = ~w_diff[9];
  assign w_rem_nxt = w_ge ? w_diff[8:0] : w_shift[8:0];
  assign w_q_nxt   = {r_q[14:0], w_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_skip ? DONE : CALC;
      CALC: if (w_last)   w_state_nxt = DONE;
      DONE: if (m_ready)  w_state_nxt = IDLE;
      default:            w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      r_div <= '0;
      r_mq  <= '0;
      r_mr  <= '0;
      r_dbz <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (s_divisor == 8'd0) begin
              r_mq  <= '1;
              r_mr  <= s_dividend[7:0];
              r_dbz <= 1'b1;
            end else if (s_dividend == 16'd0) begin
              r_mq  <= '0;
              r_mr  <= '0;
              r_dbz <= 1'b0;
            end else begin
              r_rem <= '0;
              r_q   <= s_dividend;
              r_cnt <= '0;
              r_div <= s_divisor;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (w_last) begin
            r_mq  <= w_q_nxt;
            r_mr  <= w_rem_nxt[7:0];
            r_dbz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_div_16x8_spst.sv
// Self-checking bench for restoring_div_16x8_spst: directed table, hand sequences
// for stall and mid-operation reset, and random back-to-back traffic via a scoreboard.
module tb_restoring_div_16x8_spst;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_dividend;
  logic [7:0]  s_divisor;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_quotient;
  logic [7:0]  m_remainder;
  logic        m_div_by_zero;

  restoring_div_16x8_spst dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_dividend    (s_dividend),
    .s_divisor     (s_divisor),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_quotient    (m_quotient),
    .m_remainder   (m_remainder),
    .m_div_by_zero (m_div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_res = 0;
  bit   seen = 0;
  bit   chk_rdy = 0;
  bit   rnd = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd) m_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: compares every valid cycle against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_m_valid", m_valid, 0);
      chk("rst_quotient", m_quotient, 0);
      chk("rst_remainder", m_remainder, 0);
      chk("rst_dbz", m_div_by_zero, 0);
      chk("rst_s_ready", s_ready, 0);
      sb.delete();
      seen = 0;
      chk_rdy = 0;
    end else begin
      if (chk_rdy) begin
        chk("s_ready_after_hs", s_ready, 1);
        chk("m_valid_after_hs", m_valid, 0);
        chk_rdy = 0;
      end
      if (s_valid && s_ready) n_acc++;
      if (m_valid) begin
        chk("s_ready_in_done", s_ready, 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_result: got m_valid=1 q=%0h r=%0h required no result", m_quotient, m_remainder);
        end else begin
          if (!seen) begin
            chk("latency", cyc - sb[0].acc, sb[0].lat);
            seen = 1;
          end
          chk("quotient", m_quotient, sb[0].q);
          chk("remainder", m_remainder, sb[0].r);
          chk("div_by_zero", m_div_by_zero, sb[0].dbz);
          if (m_ready) begin
            void'(sb.pop_front());
            n_res++;
            seen = 0;
            chk_rdy = 1;
          end
        end
      end
    end
  end

  task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] q, input logic [7:0] r, input logic dbz,
                       input bit hold);
    exp_t e;
    bit   ok = 0;
    @(posedge clk);
    #1;
    s_valid    = 1'b1;
    s_dividend = a;
    s_divisor  = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready && !rst) begin
        e.q   = q;
        e.r   = r;
        e.dbz = dbz;
        e.lat = (b == 8'd0 || a == 16'd0) ? 1 : 17;
        e.acc = cyc;
        sb.push_back(e);
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got s_ready=0 for 200 cycles required accept");
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      s_valid    = 1'b0;
      s_dividend = 16'($urandom);
      s_divisor  = 8'($urandom);
    end
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results required 0", sb.size());
    end
  endtask

  task automatic model(input logic [15:0] a, input logic [7:0] b,
                       output logic [15:0] q, output logic [7:0] r, output logic dbz);
    if (b == 8'd0) begin
      q = 16'hFFFF; r = a[7:0]; dbz = 1'b1;
    end else begin
      q = a / {8'd0, b}; r = 8'(a % {8'd0, b}); dbz = 1'b0;
    end
  endtask

  initial begin
    vec_t tbl[12];
    int   acc0;
    int   res0;
    logic [15:0] ra, rq;
    logic [7:0]  rb, rr;
    logic        rd;

    tbl[0]  = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0};
    tbl[1]  = '{16'hFFFF,  8'd1,   16'hFFFF,  8'd0,   1'b0};
    tbl[2]  = '{16'hFFFF,  8'd255, 16'd257,   8'd0,   1'b0};
    tbl[3]  = '{16'd500,   8'd0,   16'hFFFF,  8'hF4,  1'b1};
    tbl[4]  = '{16'd0,     8'd37,  16'd0,     8'd0,   1'b0};
    tbl[5]  = '{16'd0,     8'd0,   16'hFFFF,  8'd0,   1'b1};
    tbl[6]  = '{16'd1234,  8'd10,  16'd123,   8'd4,   1'b0};
    tbl[7]  = '{16'd9,     8'd4,   16'd2,     8'd1,   1'b0};
    tbl[8]  = '{16'd255,   8'd255, 16'd1,     8'd0,   1'b0};
    tbl[9]  = '{16'd65535, 8'd2,   16'd32767, 8'd1,   1'b0};
    tbl[10] = '{16'd7,     8'd8,   16'd0,     8'd7,   1'b0};
    tbl[11] = '{16'd40000, 8'd3,   16'd13333, 8'd1,   1'b0};

    rst        = 1'b1;
    s_valid    = 1'b0;
    s_dividend = '0;
    s_divisor  = '0;
    m_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("s_ready_idle", s_ready, 1);
    chk("m_valid_idle", m_valid, 0);

    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz, 0);
      drain();
    end

    // Stall with m_ready low and s_valid held high: exactly one handshake.
    acc0 = n_acc;
    m_ready = 1'b0;
    do_op(16'd1234, 8'd10, 16'd123, 8'd4, 1'b0, 1);
    for (int i = 0; i < 40 && !m_valid; i++) @(negedge clk);
    chk("stall_m_valid", m_valid, 1);
    repeat (5) @(negedge clk);
    chk("stall_still_valid", m_valid, 1);
    @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    chk("one_handshake", n_acc - acc0, 1);

    // Reset in the middle of CALC: no result may appear afterwards.
    do_op(16'd40000, 8'd3, 16'd13333, 8'd1, 1'b0, 0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", s_ready, 1);
    res0 = n_res;
    repeat (30) @(negedge clk);
    chk("no_result_after_rst", n_res - res0, 0);
    do_op(16'd9, 8'd4, 16'd2, 8'd1, 1'b0, 0);
    drain();

    acc0 = n_acc;
    res0 = n_res;
    rnd  = 1;
    for (int i = 0; i < 200; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      model(ra, rb, rq, rr, rd);
      do_op(ra, rb, rq, rr, rd, 0);
    end
    drain();
    rnd = 0;
    #1 m_ready = 1'b1;
    repeat (3) @(posedge clk);
    chk("random_accepts", n_acc - acc0, 200);
    chk("random_results", n_res - res0, 200);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
